// File: rtl/mac_pipe.sv
// mac_pipe: two-stage unsigned multiply-add / multiply-accumulate pipeline.
//
// Stage 1 registers the product a*b together with c and the mode bits.
// Stage 2 adds either c or the running result (accumulator) to the product
// and registers the sum and its carry-out as overflow.
//
// Build option: define MAC_PIPE_SATURATE_EN to clamp the result to all-ones
// when the sum carries out; otherwise the result wraps modulo 2^C_W.
//
// Handshake: a beat moves on a port when valid & ready are both high at a
// rising clock edge. valid never depends on ready; once out_valid is high the
// result and overflow hold until the beat is taken. in_ready is low only while
// the output beat is stalled (out_valid & ~out_ready), so the whole pipe
// freezes together and no beat is dropped, duplicated or reordered.
//
// C_W must be at least A_W+B_W so the product fits without truncation.

module mac_pipe #(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int C_W = 36
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [C_W-1:0] c,
  input  logic           acc_en,
  input  logic           acc_first,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [C_W-1:0] result,
  output logic           overflow
);

  // Pipeline control
  logic           stall;
  logic           accept;
  logic           advance;

  // Stage 1 registers
  logic           s1_valid;
  logic [C_W-1:0] s1_prod;
  logic [C_W-1:0] s1_c;
  logic           s1_acc_en;
  logic           s1_acc_first;

  // Stage 1 / stage 2 combinational datapath
  logic [C_W-1:0] prod_w;
  logic           seed_sel;
  logic [C_W-1:0] addend;
  logic [C_W:0]   sum;
  logic           carry;
  logic [C_W-1:0] next_result;
  logic           next_overflow;

  // The output register is the only place a beat can be blocked, so a stalled
  // output freezes both stages and closes the input.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign advance  = s1_valid & ~stall;

  // Unsigned product, computed at result width (no truncation since C_W >= A_W+B_W)
  always_comb begin
    prod_w = C_W'(a) * C_W'(b);
  end

  // Stage 2 adder: seed from c on add beats and chain starts, else from the result register
  always_comb begin
    seed_sel      = ~s1_acc_en | s1_acc_first;
    addend        = seed_sel ? s1_c : result;
    sum           = {1'b0, addend} + {1'b0, s1_prod};
    carry         = sum[C_W];
    next_overflow = seed_sel ? carry : (carry | overflow);
`ifdef MAC_PIPE_SATURATE_EN
    next_result   = carry ? {C_W{1'b1}} : sum[C_W-1:0];
`else
    next_result   = sum[C_W-1:0];
`endif
  end

  // Stage 1: capture product and beat attributes on accept; hold while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_prod      <= '0;
      s1_c         <= '0;
      s1_acc_en    <= 1'b0;
      s1_acc_first <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_prod      <= prod_w;
        s1_c         <= c;
        s1_acc_en    <= acc_en;
        s1_acc_first <= acc_first;
      end
    end
  end

  // Stage 2: result/overflow update on advance; the result register doubles as the accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (!stall) begin
        out_valid <= s1_valid;
      end
      if (advance) begin
        result   <= next_result;
        overflow <= next_overflow;
      end
    end
  end

endmodule
